mem_arbiter: RTL and testbench

Two-port arbiter that shares one external memory port between the instruction-cache and data-cache system (miss/refill) interfaces of `cpu`. It sits between the cpu's `IM_*`/`DM_*` system ports and a single `MEM_*` memory port. It serialises transactions with round-robin fairness and registered request capture. A per-transaction watchdog forces completion if memory never answers.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter_bus_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port memory arbiter: FSM states and bus owner codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;

endpackage

// File: rtl/mem_arbiter_bus_watchdog.sv
// Per-transaction watchdog: counts busy cycles and raises a registered expire flag.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_expire;

  // Expire is registered, so completion lands one cycle after the count hits LastCnt.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_count_en) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_expire <= (TIMEOUT != 0) && (r_cnt == LastCnt);
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction and data requesters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IM_read,
  input  logic        IM_write,
  input  logic        IM_enable,
  input  logic [31:0] IM_address,
  output logic [31:0] IM_out,
  output logic        IM_ready,
  input  logic        DM_read,
  input  logic        DM_write,
  input  logic        DM_enable,
  input  logic [31:0] DM_address,
  input  logic [31:0] DM_in,
  output logic [31:0] DM_out,
  output logic        DM_ready,
  output logic        MEM_read,
  output logic        MEM_write,
  output logic        MEM_enable,
  output logic [31:0] MEM_address,
  output logic [31:0] MEM_in,
  input  logic [31:0] MEM_out,
  input  logic        MEM_ready,
  output logic [1:0]  owner,
  output logic        bus_timeout
);

  arb_state_e r_state;
  logic [1:0] r_last_owner;

  logic w_busy;
  logic w_expire;
  logic w_grant_i;
  logic w_grant_d;
  logic w_done;

  assign w_busy    = (r_state == StBusyI) || (r_state == StBusyD);
  // On a tie the requester that did not own the bus last wins.
  assign w_grant_i = IM_enable && (!DM_enable || (r_last_owner != OWN_I));
  assign w_grant_d = DM_enable && !w_grant_i;
  assign w_done    = MEM_ready || w_expire;

  bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (r_state == StIdle),
    .i_count_en (w_busy),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_last_owner <= OWN_D;
      IM_out       <= '0;
      IM_ready     <= 1'b0;
      DM_out       <= '0;
      DM_ready     <= 1'b0;
      MEM_read     <= 1'b0;
      MEM_write    <= 1'b0;
      MEM_enable   <= 1'b0;
      MEM_address  <= '0;
      MEM_in       <= '0;
      owner        <= OWN_NONE;
      bus_timeout  <= 1'b0;
    end else begin
      IM_ready    <= 1'b0;
      DM_ready    <= 1'b0;
      bus_timeout <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_i) begin
            MEM_address  <= IM_address;
            MEM_read     <= IM_read;
            MEM_write    <= IM_write;
            MEM_in       <= '0;
            MEM_enable   <= 1'b1;
            owner        <= OWN_I;
            r_last_owner <= OWN_I;
            r_state      <= StBusyI;
          end else if (w_grant_d) begin
            MEM_address  <= DM_address;
            MEM_read     <= DM_read;
            MEM_write    <= DM_write;
            MEM_in       <= DM_in;
            MEM_enable   <= 1'b1;
            owner        <= OWN_D;
            r_last_owner <= OWN_D;
            r_state      <= StBusyD;
          end
        end
        StBusyI, StBusyD: begin
          if (w_done) begin
            // A real ready wins over a simultaneous expiry.
            if (r_state == StBusyI) begin
              IM_ready <= 1'b1;
              IM_out   <= MEM_ready ? MEM_out : '0;
            end else begin
              DM_ready <= 1'b1;
              DM_out   <= MEM_ready ? MEM_out : '0;
            end
            bus_timeout <= !MEM_ready;
            MEM_read    <= 1'b0;
            MEM_write   <= 1'b0;
            MEM_enable  <= 1'b0;
            MEM_address <= '0;
            MEM_in      <= '0;
            owner       <= OWN_NONE;
            r_state     <= StDone;
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, modelled memory, decoupled monitor.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        IM_read, IM_write, IM_enable;
  logic [31:0] IM_address;
  logic [31:0] IM_out;
  logic        IM_ready;
  logic        DM_read, DM_write, DM_enable;
  logic [31:0] DM_address, DM_in;
  logic [31:0] DM_out;
  logic        DM_ready;
  logic        MEM_read, MEM_write, MEM_enable;
  logic [31:0] MEM_address, MEM_in;
  logic [31:0] MEM_out;
  logic        MEM_ready;
  logic [1:0]  owner;
  logic        bus_timeout;

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        to;
    int unsigned busy;
  } exp_t;

  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          grants = 0;
  int unsigned busy_seen = 0;
  logic        prev_en = 1'b0;

  bit          mem_respond = 1'b1;
  int          mem_lat = 1;
  bit          use_fixed = 1'b0;
  logic [31:0] fixed_data = '0;

  mem_arbiter #(
    .TIMEOUT (4),
    .CNT_W   (7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .IM_read     (IM_read),
    .IM_write    (IM_write),
    .IM_enable   (IM_enable),
    .IM_address  (IM_address),
    .IM_out      (IM_out),
    .IM_ready    (IM_ready),
    .DM_read     (DM_read),
    .DM_write    (DM_write),
    .DM_enable   (DM_enable),
    .DM_address  (DM_address),
    .DM_in       (DM_in),
    .DM_out      (DM_out),
    .DM_ready    (DM_ready),
    .MEM_read    (MEM_read),
    .MEM_write   (MEM_write),
    .MEM_enable  (MEM_enable),
    .MEM_address (MEM_address),
    .MEM_in      (MEM_in),
    .MEM_out     (MEM_out),
    .MEM_ready   (MEM_ready),
    .owner       (owner),
    .bus_timeout (bus_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory returns the address scrambled with A5A5_0000 unless a fixed word is selected.
  assign MEM_out = use_fixed ? fixed_data : (MEM_address ^ 32'hA5A5_0000);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push(input logic is_d, input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic to,
                      input int unsigned busy);
    exp_t e;
    e.is_d = is_d; e.addr = addr; e.rd = rd; e.wr = wr;
    e.wdata = wdata; e.rdata = rdata; e.to = to; e.busy = busy;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clock);
      n++;
    end
    check(name, 128'(sb.size()), 128'(0));
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
  endtask

  // Memory model: asserts MEM_ready in busy cycle mem_lat-1 when responding.
  initial begin
    int rcnt = 0;
    MEM_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (MEM_enable && mem_respond) begin
        MEM_ready = (rcnt == mem_lat - 1);
        rcnt++;
      end else begin
        MEM_ready = 1'b0;
        rcnt = 0;
      end
    end
  end

  // Requesters keep enable high through DONE and drop it just after.
  initial forever begin
    @(negedge clock);
    if (IM_ready) begin
      @(posedge clock);
      #1;
      IM_enable = 1'b0; IM_read = 1'b0; IM_write = 1'b0;
    end
  end

  initial forever begin
    @(negedge clock);
    if (DM_ready) begin
      @(posedge clock);
      #1;
      DM_enable = 1'b0; DM_read = 1'b0; DM_write = 1'b0;
    end
  end

  // Monitor: checks bus contents while busy and completions against the scoreboard head.
  always @(negedge clock) begin
    exp_t h;
    if (MEM_enable && !prev_en) grants++;
    prev_en = MEM_enable;
    if (MEM_enable) begin
      busy_seen++;
      if (sb.size() == 0) begin
        check("bus_unexpected", 128'(1), 128'(0));
      end else begin
        h = sb[0];
        check("bus_fields", 128'({MEM_address, MEM_in, MEM_read, MEM_write, owner}),
              128'({h.addr, h.wdata, h.rd, h.wr, (h.is_d ? 2'b10 : 2'b01)}));
      end
    end else if (IM_ready || DM_ready) begin
      if (sb.size() == 0) begin
        check("ready_unexpected", 128'({IM_ready, DM_ready}), 128'(0));
      end else begin
        h = sb.pop_front();
        check("completion",
              128'({IM_ready, DM_ready, (IM_ready ? IM_out : DM_out), bus_timeout, busy_seen}),
              128'({!h.is_d, h.is_d, h.rdata, h.to, h.busy}));
      end
      busy_seen = 0;
    end else begin
      busy_seen = 0;
      if (bus_timeout) check("stray_timeout", 128'(bus_timeout), 128'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000");
    $fatal(1);
  end

  initial begin
    int g0;
    int n;
    reset = 1'b0;
    IM_read = 0; IM_write = 0; IM_enable = 0; IM_address = '0;
    DM_read = 0; DM_write = 0; DM_enable = 0; DM_address = '0; DM_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_data", 128'({IM_out, DM_out, MEM_address}), 128'(0));
    check("rst_ctrl", 128'({MEM_in, IM_ready, DM_ready, MEM_read, MEM_write, MEM_enable, owner,
                            bus_timeout}), 128'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Two simultaneous pairs out of reset: I, D, I, D.
    g0 = grants; mem_lat = 1;
    push(1'b0, 32'h2000, 1'b1, 1'b0, 32'h0, 32'hA5A5_2000, 1'b0, 1);
    push(1'b1, 32'h3000, 1'b1, 1'b0, 32'hFFFF_0000, 32'hA5A5_3000, 1'b0, 1);
    IM_address = 32'h2000; IM_read = 1; IM_enable = 1;
    DM_address = 32'h3000; DM_in = 32'hFFFF_0000; DM_read = 1; DM_enable = 1;
    wait_done("drain_pair1");
    check("grants_pair1", 128'(grants - g0), 128'(2));

    g0 = grants; mem_lat = 2;
    push(1'b0, 32'h2004, 1'b1, 1'b0, 32'h0, 32'hA5A5_2004, 1'b0, 2);
    push(1'b1, 32'h3008, 1'b1, 1'b0, 32'hFFFF_0000, 32'hA5A5_3008, 1'b0, 2);
    IM_address = 32'h2004; IM_read = 1; IM_enable = 1;
    DM_address = 32'h3008; DM_read = 1; DM_enable = 1;
    wait_done("drain_pair2");
    check("grants_pair2", 128'(grants - g0), 128'(2));

    // Single I read, ready in the third busy cycle.
    g0 = grants; mem_lat = 3; use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
    push(1'b0, 32'h1000, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    IM_address = 32'h1000; IM_read = 1; IM_enable = 1;
    wait_done("drain_iread");
    check("grants_iread", 128'(grants - g0), 128'(1));
    check("im_out_hold", 128'(IM_out), 128'(32'hDEAD_BEEF));
    use_fixed = 1'b0;

    // D write.
    g0 = grants; mem_lat = 2;
    push(1'b1, 32'h100, 1'b0, 1'b1, 32'h1234, 32'hA5A5_0100, 1'b0, 2);
    DM_address = 32'h100; DM_in = 32'h1234; DM_write = 1; DM_read = 0; DM_enable = 1;
    wait_done("drain_dwrite");
    check("grants_dwrite", 128'(grants - g0), 128'(1));
    check("im_out_after_d", 128'(IM_out), 128'(32'hDEAD_BEEF));

    // Watchdog: no ready, TIMEOUT=4 gives 5 busy cycles, zero data, timeout pulse.
    g0 = grants; mem_respond = 1'b0;
    push(1'b1, 32'h200, 1'b1, 1'b0, 32'h1234, 32'h0, 1'b1, 5);
    DM_address = 32'h200; DM_read = 1; DM_write = 0; DM_enable = 1;
    wait_done("drain_timeout");
    check("grants_timeout", 128'(grants - g0), 128'(1));
    check("dm_out_timeout", 128'(DM_out), 128'(0));

    // Reset in the middle of an I transaction.
    push(1'b0, 32'h400, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 0);
    IM_address = 32'h400; IM_read = 1; IM_enable = 1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!MEM_enable && n < 10);
    check("midrst_busy", 128'(MEM_enable), 128'(1));
    reset = 1'b0; IM_enable = 0; IM_read = 0;
    @(negedge clock);
    check("midrst_data", 128'({IM_out, DM_out, MEM_address}), 128'(0));
    check("midrst_ctrl", 128'({MEM_in, IM_ready, DM_ready, MEM_read, MEM_write, MEM_enable, owner,
                               bus_timeout}), 128'(0));
    sb.delete();
    reset = 1'b1; mem_respond = 1'b1;
    @(posedge clock); #1;

    // Tie after reset must grant I first again.
    g0 = grants; mem_lat = 1;
    push(1'b0, 32'h500, 1'b1, 1'b0, 32'h0, 32'hA5A5_0500, 1'b0, 1);
    push(1'b1, 32'h600, 1'b1, 1'b0, 32'h0, 32'hA5A5_0600, 1'b0, 1);
    IM_address = 32'h500; IM_read = 1; IM_enable = 1;
    DM_address = 32'h600; DM_in = 32'h0; DM_read = 1; DM_enable = 1;
    wait_done("drain_postrst");
    check("grants_postrst", 128'(grants - g0), 128'(2));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
